// File: rtl/cam_bringup_seq.sv
// cam_bringup_seq: power-up and bring-up sequencer for the OV5642 camera path.
// Walks the sensor through power-down, reset and boot delays, kicks the SCCB
// init engine, then waits for live frames (synced vsync edges) before enabling
// the video datapath. Failures trigger a full power cycle up to MAX_RETRIES
// times, after which a sticky failure is reported.
// Optional build macro CAM_BRINGUP_WATCHDOG_EN: supervise vsync while in RUN
// and treat a lost frame stream as a failure.
module cam_bringup_seq #(
    parameter int PWDN_CYC         = 100000,
    parameter int RST_CYC          = 100000,
    parameter int BOOT_CYC         = 2000000,
    parameter int INIT_TIMEOUT_CYC = 50000000,
    parameter int VSYNC_FRAMES     = 2,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 26
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_sccb_done,
    input  logic       i_sccb_error,
    input  logic       i_dvp_vsync,
    output logic       o_cam_pwdn,
    output logic       o_cam_resetb,
    output logic       o_sccb_rst,
    output logic       o_sccb_start,
    output logic       o_video_en,
    output logic       o_fail,
    output logic [1:0] o_retry_cnt,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_PWDN        = 4'd1,
        S_RESET       = 4'd2,
        S_BOOT        = 4'd3,
        S_START       = 4'd4,
        S_WAIT_INIT   = 4'd5,
        S_WAIT_FRAMES = 4'd6,
        S_RUN         = 4'd7,
        S_FAIL        = 4'd8
    } state_t;

    localparam int FRM_W = (VSYNC_FRAMES > 1) ? $clog2(VSYNC_FRAMES) : 1;
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);
    localparam logic [FRM_W-1:0] LAST_FRAME  = FRM_W'(VSYNC_FRAMES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             timer_done;
    logic [FRM_W-1:0] frm_cnt;
    logic [FRM_W-1:0] frm_nxt;
    logic [1:0]       retry_nxt;
    logic             fail_evt;
    logic             pwdn_nxt;
    logic             resetb_nxt;
    logic             sccb_rst_nxt;
    logic             start_nxt;
    logic             video_nxt;
    logic             fail_nxt;
    logic             vs_meta;
    logic             vs_sync;
    logic             vs_prev;
    logic             vs_edge;

    // Timer reload value on entry: a timed state lasts exactly N cycles,
    // so the counter starts at N-1 and the state exits when it reads zero.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        case (s)
            S_PWDN:                           return CNT_W'(PWDN_CYC - 1);
            S_RESET:                          return CNT_W'(RST_CYC - 1);
            S_BOOT:                           return CNT_W'(BOOT_CYC - 1);
            S_WAIT_INIT, S_WAIT_FRAMES, S_RUN: return CNT_W'(INIT_TIMEOUT_CYC - 1);
            default:                          return '0;
        endcase
    endfunction

    assign timer_done = (timer == '0);
    assign o_state    = state;

    // Two-flop vsync synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
            vs_edge <= 1'b0;
        end else begin
            vs_meta <= i_dvp_vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            vs_edge <= vs_sync & ~vs_prev;
        end
    end

    // Next-state, timer/frame/retry bookkeeping and output decode.
    always_comb begin
        next_state = state;
        timer_nxt  = timer_done ? timer : timer - CNT_W'(1);
        frm_nxt    = frm_cnt;
        retry_nxt  = o_retry_cnt;
        fail_evt   = 1'b0;

        case (state)
            S_IDLE:  if (i_enable) next_state = S_PWDN;
            S_PWDN:  if (timer_done) next_state = S_RESET;
            S_RESET: if (timer_done) next_state = S_BOOT;
            S_BOOT:  if (timer_done) next_state = S_START;
            S_START: next_state = S_WAIT_INIT;
            S_WAIT_INIT: begin
                // Error outranks done when both are flagged together.
                if (i_sccb_error)     fail_evt   = 1'b1;
                else if (i_sccb_done) next_state = S_WAIT_FRAMES;
                else if (timer_done)  fail_evt   = 1'b1;
            end
            S_WAIT_FRAMES: begin
                if (vs_edge) begin
                    if (frm_cnt == LAST_FRAME) next_state = S_RUN;
                    else                       frm_nxt    = frm_cnt + FRM_W'(1);
                end else if (timer_done) begin
                    fail_evt = 1'b1;
                end
            end
            S_RUN: begin
`ifdef CAM_BRINGUP_WATCHDOG_EN
                // Every live frame re-arms the watchdog; silence means lost video.
                if (vs_edge)         timer_nxt = load_val(S_RUN);
                else if (timer_done) fail_evt  = 1'b1;
`endif
            end
            S_FAIL:  next_state = S_FAIL;
            default: next_state = S_IDLE;
        endcase

        if (fail_evt) begin
            if (o_retry_cnt < RETRY_LIMIT) begin
                retry_nxt  = o_retry_cnt + 2'd1;
                next_state = S_PWDN;
            end else begin
                next_state = S_FAIL;
            end
        end

        // Dropping enable aborts from anywhere, including mid-timer and RUN.
        if (!i_enable) next_state = S_IDLE;
        if (next_state == S_IDLE) retry_nxt = '0;

        if (next_state != state) begin
            timer_nxt = load_val(next_state);
            frm_nxt   = '0;
        end

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register.
        pwdn_nxt     = (next_state inside {S_IDLE, S_PWDN, S_FAIL});
        resetb_nxt   = (next_state inside {S_BOOT, S_START, S_WAIT_INIT, S_WAIT_FRAMES, S_RUN});
        sccb_rst_nxt = (next_state inside {S_IDLE, S_PWDN, S_RESET, S_BOOT, S_FAIL});
        start_nxt    = (next_state == S_START);
        video_nxt    = (next_state == S_RUN);
        fail_nxt     = (next_state == S_FAIL);
    end

    // State register plus registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            frm_cnt      <= '0;
            o_retry_cnt  <= '0;
            o_cam_pwdn   <= 1'b1;
            o_cam_resetb <= 1'b0;
            o_sccb_rst   <= 1'b1;
            o_sccb_start <= 1'b0;
            o_video_en   <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            state        <= next_state;
            timer        <= timer_nxt;
            frm_cnt      <= frm_nxt;
            o_retry_cnt  <= retry_nxt;
            o_cam_pwdn   <= pwdn_nxt;
            o_cam_resetb <= resetb_nxt;
            o_sccb_rst   <= sccb_rst_nxt;
            o_sccb_start <= start_nxt;
            o_video_en   <= video_nxt;
            o_fail       <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_cam_bringup_seq.sv
// Testbench for cam_bringup_seq: scheduled randomized stimulus pushes the
// expected state transitions (state, cycle, retry count) into a queue; an
// independent monitor pops them as the DUT changes state and also checks the
// per-state output pattern every cycle.
module tb_cam_bringup_seq;

    localparam int P  = 4;
    localparam int R  = 4;
    localparam int B  = 8;
    localparam int TO = 50;
    localparam int WI = P + R + B + 1;   // PWDN entry to WAIT_INIT entry

    typedef struct {
        int st;
        int cyc;
        int retry;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sccb_done = 1'b0;
    logic       sccb_error = 1'b0;
    logic       dvp_vsync = 1'b0;
    logic       cam_pwdn, cam_resetb, sccb_rst, sccb_start, video_en, fail;
    logic [1:0] retry_cnt;
    logic [3:0] state;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  start_cnt = 0;
    bit  mon_en = 1'b0;
    int  prev_st = 0;
    int  cur_st = 0;
    int  cur_retry = 0;
    ev_t mon_e;
    ev_t exp_q[$];

    cam_bringup_seq #(
        .PWDN_CYC(P), .RST_CYC(R), .BOOT_CYC(B), .INIT_TIMEOUT_CYC(TO),
        .VSYNC_FRAMES(2), .MAX_RETRIES(2), .CNT_W(26)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .i_sccb_done(sccb_done), .i_sccb_error(sccb_error), .i_dvp_vsync(dvp_vsync),
        .o_cam_pwdn(cam_pwdn), .o_cam_resetb(cam_resetb), .o_sccb_rst(sccb_rst),
        .o_sccb_start(sccb_start), .o_video_en(video_en), .o_fail(fail),
        .o_retry_cnt(retry_cnt), .o_state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output pattern per state: {pwdn, resetb, sccb_rst, start, video_en, fail}
    function automatic logic [5:0] exp_outs(input int s);
        case (s)
            0:       return 6'b101000;
            1:       return 6'b101000;
            2:       return 6'b001000;
            3:       return 6'b011000;
            4:       return 6'b010100;
            5, 6:    return 6'b010000;
            7:       return 6'b010010;
            8:       return 6'b101001;
            default: return 6'b000000;
        endcase
    endfunction

    // Monitor: pops an expected transition whenever the DUT state changes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sccb_start) start_cnt++;
            if (int'(state) != prev_st) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_transition: got state %0d at cycle %0d, required no transition",
                             state, cyc);
                    cur_st    = int'(state);
                    cur_retry = int'(retry_cnt);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(state) != mon_e.st || cyc != mon_e.cyc || int'(retry_cnt) != mon_e.retry) begin
                        fails++;
                        $display("FAIL transition: got state %0d cycle %0d retry %0d, required state %0d cycle %0d retry %0d",
                                 state, cyc, retry_cnt, mon_e.st, mon_e.cyc, mon_e.retry);
                    end
                    cur_st    = mon_e.st;
                    cur_retry = mon_e.retry;
                end
                prev_st = int'(state);
            end
            tests++;
            if ({cam_pwdn, cam_resetb, sccb_rst, sccb_start, video_en, fail} != exp_outs(cur_st) ||
                int'(retry_cnt) != cur_retry) begin
                fails++;
                $display("FAIL outputs@%0d: got outs %b retry %0d, required outs %b retry %0d (state %0d)",
                         cyc, {cam_pwdn, cam_resetb, sccb_rst, sccb_start, video_en, fail},
                         retry_cnt, exp_outs(cur_st), cur_retry, cur_st);
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input int st, input int c, input int r);
        ev_t e;
        e.st = st; e.cyc = c; e.retry = r;
        exp_q.push_back(e);
    endtask

    // Power cycle from PWDN entry at cycle tp through to WAIT_INIT.
    task automatic push_powerup(input int tp, input int r);
        push(1, tp, r);
        push(2, tp + P, r);
        push(3, tp + P + R, r);
        push(4, tp + P + R + B, r);
        push(5, tp + WI, r);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise enable now and drive a successful init with two vsync frames.
    task automatic bring_to_run(input int r, output int t_run);
        int t0, td, wf, r1, r2, h, l;
        t0 = cyc;
        enable = 1'b1;
        push_powerup(t0 + 1, r);
        td = t0 + 1 + WI + int'($urandom_range(0, 19));
        wait_until(td);
        sccb_done = 1'b1;
        wf = td + 1;
        push(6, wf, r);
        wait_until(wf);
        sccb_done = 1'b0;
        r1 = wf + int'($urandom_range(0, 5));
        h  = int'($urandom_range(1, 4));
        l  = int'($urandom_range(1, 4));
        r2 = r1 + h + l;
        wait_until(r1);
        dvp_vsync = 1'b1;
        wait_until(r1 + h);
        dvp_vsync = 1'b0;
        wait_until(r2);
        dvp_vsync = 1'b1;
        push(7, r2 + 4, r);   // 3 cycles to a visible edge, then the state register
        wait_until(r2 + 2);
        dvp_vsync = 1'b0;
        t_run = r2 + 4;
        wait_until(t_run);
    endtask

    initial begin
        int t0, td, wf, t_run, k, s0, r1, r2, c;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_outs", int'({cam_pwdn, cam_resetb, sccb_rst, sccb_start, video_en, fail}), 6'b101000);
        check("reset_retry", int'(retry_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        wait_until(cyc + 3);

        // Nominal bring-up, then disable while in RUN
        bring_to_run(0, t_run);
        k = int'($urandom_range(1, 15));
        wait_until(t_run + k);
        enable = 1'b0;
        push(0, t_run + k + 1, 0);
        wait_until(cyc + 3);

        // Simultaneous done+error, then WAIT_FRAMES timeout, then error at limit -> FAIL
        t0 = cyc;
        enable = 1'b1;
        push_powerup(t0 + 1, 0);
        td = t0 + 1 + WI + int'($urandom_range(0, 20));
        wait_until(td);
        sccb_done = 1'b1;
        sccb_error = 1'b1;
        push_powerup(td + 1, 1);
        wait_until(td + 1);
        sccb_done = 1'b0;
        sccb_error = 1'b0;
        td = td + 1 + WI + int'($urandom_range(0, 20));
        wait_until(td);
        sccb_done = 1'b1;
        wf = td + 1;
        push(6, wf, 1);
        wait_until(wf);
        sccb_done = 1'b0;
        push_powerup(wf + TO, 2);
        td = wf + TO + WI + int'($urandom_range(0, 20));
        wait_until(td);
        sccb_error = 1'b1;
        push(8, td + 1, 2);
        wait_until(td + 1);
        sccb_error = 1'b0;
        wait_until(td + 1 + int'($urandom_range(5, 15)));
        c = cyc;
        enable = 1'b0;
        push(0, c + 1, 0);
        wait_until(cyc + 3);

        // Persistent timeout: done never arrives
        s0 = start_cnt;
        t0 = cyc;
        enable = 1'b1;
        push_powerup(t0 + 1, 0);
        push_powerup(t0 + 1 + WI + TO, 1);
        push_powerup(t0 + 1 + 2 * (WI + TO), 2);
        push(8, t0 + 1 + 3 * WI + 3 * TO, 2);
        wait_until(t0 + 1 + 3 * WI + 3 * TO + 30);
        @(negedge clk);
        check("timeout_start_pulses", start_cnt - s0, 3);
        check("timeout_fail_flag", int'(fail), 1);
        check("timeout_pwdn", int'(cam_pwdn), 1);
        check("timeout_video_en", int'(video_en), 0);
        c = cyc;
        enable = 1'b0;
        push(0, c + 1, 0);
        wait_until(cyc + 3);

        // Disable in BOOT with a retry already consumed
        t0 = cyc;
        enable = 1'b1;
        push_powerup(t0 + 1, 0);
        td = t0 + 1 + WI + int'($urandom_range(0, 20));
        wait_until(td);
        sccb_error = 1'b1;
        push(1, td + 1, 1);
        push(2, td + 1 + P, 1);
        push(3, td + 1 + P + R, 1);
        wait_until(td + 1);
        sccb_error = 1'b0;
        k = int'($urandom_range(0, B - 1));
        wait_until(td + 1 + P + R + k);
        enable = 1'b0;
        push(0, td + 2 + P + R + k, 0);
        wait_until(cyc + 2);

        // Re-enable restarts at PWDN; reset lands with the 2nd vsync edge
        t0 = cyc;
        enable = 1'b1;
        push_powerup(t0 + 1, 0);
        td = t0 + 1 + WI + int'($urandom_range(0, 10));
        wait_until(td);
        sccb_done = 1'b1;
        wf = td + 1;
        push(6, wf, 0);
        wait_until(wf);
        sccb_done = 1'b0;
        r1 = wf + int'($urandom_range(0, 3));
        r2 = r1 + 4;
        wait_until(r1);
        dvp_vsync = 1'b1;
        wait_until(r1 + 2);
        dvp_vsync = 1'b0;
        wait_until(r2);
        dvp_vsync = 1'b1;
        wait_until(r2 + 3);
        rst = 1'b1;
        push(0, r2 + 4, 0);
        wait_until(r2 + 4);
        rst = 1'b0;
        enable = 1'b0;
        dvp_vsync = 1'b0;
        wait_until(cyc + 5);

`ifdef CAM_BRINGUP_WATCHDOG_EN
        // Vsync stops in RUN: watchdog expiry is a fail event
        bring_to_run(0, t_run);
        push_powerup(t_run + TO, 1);
        wait_until(t_run + TO + 3);
        enable = 1'b0;
        push(0, t_run + TO + 4, 0);
        wait_until(cyc + 3);
`endif

        wait_until(cyc + 5);
        @(negedge clk);
        check("expected_transitions_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
